// File: rtl/cpu_step_ctrl.sv
// Run/pause/single-step clock-enable controller for a soft CPU.
// Also picks which CPU observation bus goes to an 8-digit display.
module cpu_step_ctrl #(
  parameter int DIV = 100000,
  parameter int DEB = 20,
  parameter int ROT = 50000000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic [1:0]  res_choose,
  input  logic        auto_rot,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [31:0] result,
  output logic        cpu_ce,
  output logic [31:0] seg_data,
  output logic [1:0]  src,
  output logic [31:0] cycle_cnt,
  output logic [1:0]  mode
);

  localparam int DIV_W = $clog2(DIV);
  localparam int DEB_W = $clog2(DEB + 1);
  localparam int ROT_W = $clog2(ROT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB - 1);
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT - 1);

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2
  } state_t;

  // Button conditioning; bit 0 = run, bit 1 = step.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       db_lvl;
  logic [1:0]       db_prev;
  logic [1:0]       press;
  logic [DEB_W-1:0] deb_cnt [2];

  assign btn_raw = {btn_step, btn_run};

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      db_lvl  <= '0;
      db_prev <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      db_prev <= db_lvl;
      // The level only follows after DEB consecutive disagreeing samples.
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          db_lvl[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign press = db_lvl & ~db_prev & {2{reset}};

  // Control FSM
  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk_in) begin
    if (!reset) state <= PAUSE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PAUSE: begin
        if (press[0])      state_nxt = RUN;
        else if (press[1]) state_nxt = STEP;
      end
      RUN: begin
        if (press[0]) state_nxt = PAUSE;
      end
      STEP:    state_nxt = PAUSE;
      default: state_nxt = PAUSE;
    endcase
  end

  assign mode = state;

  // Run-mode divider, held at zero outside RUN so entry always waits DIV cycles.
  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk_in) begin
    if (!reset || state != RUN) div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                          div_cnt <= div_cnt + DIV_W'(1);
  end

  assign cpu_ce = (state == STEP) || ((state == RUN) && (div_cnt == DIV_LAST));

  always_ff @(posedge clk_in) begin
    if (!reset)                          cycle_cnt <= '0;
    else if (cpu_ce && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Display source rotation and selection
  logic [ROT_W-1:0] dwell;
  logic [1:0]       rot_idx;
  logic [1:0]       sel_src;
  logic [31:0]      sel_data;

  always_ff @(posedge clk_in) begin
    if (!reset || !auto_rot) begin
      dwell   <= '0;
      rot_idx <= '0;
    end else if (dwell == ROT_LAST) begin
      dwell   <= '0;
      rot_idx <= (rot_idx == 2'd2) ? 2'd0 : rot_idx + 2'd1;
    end else begin
      dwell <= dwell + ROT_W'(1);
    end
  end

  always_comb begin
    sel_src = 2'd0;
    if (auto_rot)           sel_src = rot_idx;
    else if (res_choose[1]) sel_src = 2'd2;
    else if (res_choose[0]) sel_src = 2'd1;
    sel_data = result;
    case (sel_src)
      2'd1:    sel_data = pc;
      2'd2:    sel_data = inst;
      default: sel_data = result;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      src      <= '0;
      seg_data <= '0;
    end else begin
      src      <= sel_src;
      seg_data <= sel_data;
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DIV=4, DEB=3, ROT=8.
// Expected values are hand-derived cycle by cycle from the button pipeline depth.
module tb_cpu_step_ctrl;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        btn_run;
  logic        btn_step;
  logic [1:0]  res_choose;
  logic        auto_rot;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] result;
  logic        cpu_ce;
  logic [31:0] seg_data;
  logic [1:0]  src;
  logic [31:0] cycle_cnt;
  logic [1:0]  mode;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [1:0]  exp_src;
  logic [31:0] exp_seg;

  cpu_step_ctrl #(.DIV(4), .DEB(3), .ROT(8)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .btn_run    (btn_run),
    .btn_step   (btn_step),
    .res_choose (res_choose),
    .auto_rot   (auto_rot),
    .pc         (pc),
    .inst       (inst),
    .result     (result),
    .cpu_ce     (cpu_ce),
    .seg_data   (seg_data),
    .src        (src),
    .cycle_cnt  (cycle_cnt),
    .mode       (mode)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  // Advance n rising edges, then settle 1 time unit before sampling/driving.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    btn_run    = 1'b0;
    btn_step   = 1'b0;
    res_choose = 2'b00;
    auto_rot   = 1'b0;
    pc         = 32'h0040_0000;
    inst       = 32'h3C01_0001;
    result     = 32'h1234_5678;

    // Reset state
    tick(3);
    check("rst_mode", mode, 0);
    check("rst_ce", cpu_ce, 0);
    check("rst_cnt", cycle_cnt, 0);
    check("rst_seg", seg_data, 0);
    check("rst_src", src, 0);
    reset = 1'b1;

    // Idle: no presses for 100 cycles
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check("idle_mode", mode, 0);
      check("idle_ce", cpu_ce, 0);
      check("idle_cnt", cycle_cnt, 0);
    end
    check("idle_seg", seg_data, 32'h1234_5678);

    // Run press: 2 sync + 3 debounce edges, then FSM moves on the next edge
    btn_run = 1'b1;
    tick(5);
    check("run_pending", mode, 0);
    tick(1);
    check("run_enter", mode, 1);
    check("run_cnt0", cycle_cnt, 0);
    // Divider 0 on entry, so pulses at every 4th edge: i = 2, 6, 10, ...
    for (int i = 0; i < 40; i++) begin
      if (i == 4)  btn_run = 1'b0;
      if (i == 20) btn_step = 1'b1;
      if (i == 28) btn_step = 1'b0;
      tick(1);
      check("run_ce", cpu_ce, (i % 4 == 2) ? 1 : 0);
      check("run_mode", mode, 1);
      if (i == 19) check("run_cnt5", cycle_cnt, 5);
    end
    check("run_cnt10", cycle_cnt, 10);

    // Pause press; divider keeps going until the FSM leaves RUN
    btn_run = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick(1);
      check("pause_ce", cpu_ce, (j == 2) ? 1 : 0);
      check("pause_mode", mode, (j == 5) ? 0 : 1);
    end
    btn_run = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick(1);
      check("paused_ce", cpu_ce, 0);
      check("paused_mode", mode, 0);
    end
    check("pause_cnt", cycle_cnt, 11);

    // Single step while paused
    btn_step = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j == 6) btn_step = 1'b0;
      tick(1);
      check("step_ce", cpu_ce, (j == 5) ? 1 : 0);
      check("step_mode", mode, (j == 5) ? 2 : 0);
    end
    tick(8);
    check("step_cnt", cycle_cnt, 12);
    check("step_back", mode, 0);

    // Bouncing step button: never stable for 3 cycles
    for (int j = 0; j < 20; j++) begin
      btn_step = ((j / 2) % 2 == 0);
      tick(1);
      check("bounce_ce", cpu_ce, 0);
      check("bounce_mode", mode, 0);
    end
    btn_step = 1'b0;
    tick(10);
    check("bounce_cnt", cycle_cnt, 12);
    check("bounce_mode_end", mode, 0);

    // Auto rotation: 8-cycle dwell per source
    auto_rot = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick(1);
      if (k < 8)       begin exp_src = 2'd0; exp_seg = 32'h1234_5678; end
      else if (k < 16) begin exp_src = 2'd1; exp_seg = 32'h0040_0000; end
      else if (k < 24) begin exp_src = 2'd2; exp_seg = 32'h3C01_0001; end
      else             begin exp_src = 2'd0; exp_seg = 32'h1234_5678; end
      check("rot_src", src, exp_src);
      check("rot_seg", seg_data, exp_seg);
    end

    // Manual selection
    auto_rot   = 1'b0;
    res_choose = 2'b10;
    tick(1);
    check("man10_src", src, 2);
    check("man10_seg", seg_data, 32'h3C01_0001);
    res_choose = 2'b01;
    check("man_hold", seg_data, 32'h3C01_0001);
    tick(1);
    check("man01_src", src, 1);
    check("man01_seg", seg_data, 32'h0040_0000);
    res_choose = 2'b11;
    tick(1);
    check("man11_src", src, 2);
    check("man11_seg", seg_data, 32'h3C01_0001);
    res_choose = 2'b00;
    tick(1);
    check("man00_src", src, 0);
    check("man00_seg", seg_data, 32'h1234_5678);
    result = 32'hDEAD_BEEF;
    tick(1);
    check("man_follow", seg_data, 32'hDEAD_BEEF);
    result = 32'h1234_5678;
    tick(1);

    // Reset asserted mid-RUN with divider at 2
    btn_run = 1'b1;
    tick(5);
    check("rr_pending", mode, 0);
    tick(1);
    check("rr_enter", mode, 1);
    btn_run = 1'b0;
    tick(2);
    check("rr_ce_pre", cpu_ce, 0);
    check("rr_cnt_pre", cycle_cnt, 12);
    reset = 1'b0;
    tick(1);
    check("rr_mode", mode, 0);
    check("rr_cnt", cycle_cnt, 0);
    check("rr_ce", cpu_ce, 0);
    check("rr_src", src, 0);
    check("rr_seg", seg_data, 0);
    tick(1);
    check("rr_ce2", cpu_ce, 0);
    reset = 1'b1;
    tick(10);
    check("post_mode", mode, 0);
    check("post_ce", cpu_ce, 0);
    check("post_cnt", cycle_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
